// File: rtl/std_reg_ctrl_pkg.sv
// Shared definitions for the register-write handshake controllers:
// the initiator state encoding and its default watchdog length.
package std_reg_ctrl_pkg;

    localparam int STATE_W         = 2;
    localparam int DEFAULT_TIMEOUT = 8;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        ERR   = 2'd2
    } state_t;

    // Width of a counter that must reach limit-1; never narrower than one bit.
    function automatic int waitWidth(input int limit);
        return (limit <= 2) ? 1 : $clog2(limit);
    endfunction

endpackage

// File: rtl/std_reg_write_initiator.sv
// Initiator end of the write_en/done register-write handshake.
// Takes one request at a time from a valid/ready source, holds write_en and
// the data on a downstream register until it answers with done, counts
// completed writes and parks in an error state if done never arrives.
module std_reg_write_initiator
    import std_reg_ctrl_pkg::*;
#(
    parameter int WIDTH   = 3,
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic [WIDTH-1:0] req_data,
    output logic             req_ready,
    output logic [WIDTH-1:0] reg_in,
    output logic             reg_write_en,
    input  logic             reg_done,
    input  logic             clear_err,
    output logic             busy,
    output logic             err_timeout,
    output logic [CNT_W-1:0] writes_done
);

    localparam int                WAIT_W    = waitWidth(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               live_q;

    // State, latched data and counters; everything returns to idle on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            wait_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            wait_q  <= wait_d;
            cnt_q   <= cnt_d;
        end
    end

    // Holds ready low while in reset and rises on the first clock after release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            live_q <= 1'b0;
        end else begin
            live_q <= 1'b1;
        end
    end

    // Next-state logic: a done in the first ISSUE cycle is a leftover from the
    // previous write and is ignored; a valid done beats the watchdog.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        wait_d  = wait_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    data_d  = req_data;
                    wait_d  = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (reg_done && (wait_q != '0)) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = IDLE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = ERR;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ERR: begin
                if (clear_err) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign req_ready    = live_q && (state_q == IDLE);
    assign reg_write_en = (state_q == ISSUE);
    assign busy         = (state_q == ISSUE);
    assign err_timeout  = (state_q == ERR);
    assign reg_in       = data_q;
    assign writes_done  = cnt_q;

endmodule

// File: tb/tb_std_reg_write_initiator.sv
// Bench for the register-write initiator: drives directed and random writes
// into a model downstream register with a registered done and compares the
// results against a transaction-level expectation.
module tb_std_reg_write_initiator;

    logic       clk       = 1'b0;
    logic       reset     = 1'b1;
    logic       req_valid = 1'b0;
    logic [2:0] req_data  = 3'd0;
    logic       clear_err = 1'b0;
    logic       reg_done;

    logic       req_ready, reg_write_en, busy, err_timeout;
    logic [2:0] reg_in;
    logic [7:0] writes_done;

    logic       readyB, writeEnB, busyB, errB;
    logic [2:0] regInB;
    logic [1:0] writesDoneB;

    logic       useModel  = 1'b1;
    logic       forceDone = 1'b0;
    logic [2:0] modelReg;
    logic       doneQ;

    int         checks   = 0;
    int         errors   = 0;
    int         expCount = 0;
    logic [2:0] expReg   = 3'd0;

    std_reg_write_initiator #(.WIDTH(3), .TIMEOUT(8), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .reg_in(reg_in), .reg_write_en(reg_write_en),
        .reg_done(reg_done), .clear_err(clear_err), .busy(busy),
        .err_timeout(err_timeout), .writes_done(writes_done)
    );

    std_reg_write_initiator #(.WIDTH(3), .TIMEOUT(8), .CNT_W(2)) dutNarrow (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(readyB), .reg_in(regInB), .reg_write_en(writeEnB),
        .reg_done(reg_done), .clear_err(clear_err), .busy(busyB),
        .err_timeout(errB), .writes_done(writesDoneB)
    );

    always #5 clk = ~clk;

    // Downstream single-cycle register: captures on write_en, done one cycle later.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            modelReg <= 3'd0;
            doneQ    <= 1'b0;
        end else begin
            if (reg_write_en) modelReg <= reg_in;
            doneQ <= reg_write_en;
        end
    end

    assign reg_done = useModel ? doneQ : forceDone;

    // Overall time limit so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=running expected=finished");
        $fatal(1, "[TB] time limit reached");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, "_count"}, 32'(writes_done), 32'(expCount & 255));
        checkOutput({tag, "_count_w2"}, 32'(writesDoneB), 32'(expCount & 3));
        checkOutput({tag, "_reg"}, 32'(modelReg), 32'(expReg));
    endtask

    // One request from IDLE; either the register answers or done stays low.
    task automatic applyStimulus(input logic [2:0] d, input logic tieLow,
                                 output int enCycles, output int latency);
        useModel  = !tieLow;
        forceDone = 1'b0;
        req_valid = 1'b1;
        req_data  = d;
        checkOutput("ready_before_accept", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        enCycles  = 0;
        latency   = 0;
        for (int i = 0; i < 40 && busy; i++) begin
            if (reg_write_en) enCycles++;
            latency++;
            tick();
        end
        checkOutput("issue_bounded", 32'(busy), 32'd0);
        expReg = d;
        if (!tieLow) expCount++;
    endtask

    initial begin
        int en, lat, accepted, enSeen;
        logic [2:0] d;
        logic tie;

        // Reset state while reset is held.
        tick();
        tick();
        checkOutput("rst_write_en", 32'(reg_write_en), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_err", 32'(err_timeout), 32'd0);
        checkOutput("rst_reg_in", 32'(reg_in), 32'd0);
        checkOutput("rst_ready", 32'(req_ready), 32'd0);
        checkModel("rst");
        reset = 1'b0;
        tick();
        checkOutput("ready_after_release", 32'(req_ready), 32'd1);

        // Reset in the middle of an ISSUE: write_en must drop immediately.
        req_valid = 1'b1;
        req_data  = 3'b101;
        tick();
        req_valid = 1'b0;
        checkOutput("mid_issue_write_en", 32'(reg_write_en), 32'd1);
        checkOutput("mid_issue_reg_in", 32'(reg_in), 32'd5);
        #2 reset = 1'b1;
        #1;
        checkOutput("async_rst_write_en", 32'(reg_write_en), 32'd0);
        checkOutput("async_rst_busy", 32'(busy), 32'd0);
        checkOutput("async_rst_reg_in", 32'(reg_in), 32'd0);
        checkOutput("async_rst_count", 32'(writes_done), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        checkOutput("ready_after_rst2", 32'(req_ready), 32'd1);
        checkOutput("idle_after_rst2", 32'(busy), 32'd0);

        // Single write of 6: two write_en cycles, ready back on the third edge.
        applyStimulus(3'b110, 1'b0, en, lat);
        checkOutput("single_en_cycles", 32'(en), 32'd2);
        checkOutput("single_latency", 32'(lat), 32'd2);
        checkOutput("single_ready", 32'(req_ready), 32'd1);
        checkModel("single");

        // Back-to-back 1,2,3 with valid held: three writes in nine cycles.
        accepted  = 0;
        enSeen    = 0;
        useModel  = 1'b1;
        req_valid = 1'b1;
        req_data  = 3'd1;
        for (int c = 0; c < 9; c++) begin
            logic acc;
            acc = req_ready;
            if (reg_write_en) enSeen++;
            tick();
            if (acc) begin
                accepted++;
                if (accepted < 3) req_data = 3'(accepted + 1);
                else req_valid = 1'b0;
            end
        end
        expCount += 3;
        expReg = 3'd3;
        checkOutput("b2b_accepted", 32'(accepted), 32'd3);
        checkOutput("b2b_en_cycles", 32'(enSeen), 32'd6);
        checkOutput("b2b_ready", 32'(req_ready), 32'd1);
        checkModel("b2b");
        tick();
        checkModel("b2b_stale");

        // Done tied low: eight ISSUE cycles, then ERR until cleared.
        applyStimulus(3'b011, 1'b1, en, lat);
        checkOutput("timeout_en_cycles", 32'(en), 32'd8);
        checkOutput("timeout_err", 32'(err_timeout), 32'd1);
        checkOutput("timeout_ready", 32'(req_ready), 32'd0);
        checkOutput("timeout_write_en", 32'(reg_write_en), 32'd0);
        checkModel("timeout");
        forceDone = 1'b1;
        tick();
        forceDone = 1'b0;
        checkOutput("err_done_ignored", 32'(err_timeout), 32'd1);
        checkModel("err_done");
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        checkOutput("clear_err", 32'(err_timeout), 32'd0);
        checkOutput("clear_ready", 32'(req_ready), 32'd1);

        // Done arrives on the last permitted ISSUE cycle: completes, no error.
        useModel  = 1'b0;
        forceDone = 1'b0;
        req_valid = 1'b1;
        req_data  = 3'd4;
        tick();
        req_valid = 1'b0;
        repeat (7) tick();
        checkOutput("last_cycle_busy", 32'(busy), 32'd1);
        forceDone = 1'b1;
        tick();
        forceDone = 1'b0;
        expCount++;
        expReg = 3'd4;
        checkOutput("last_cycle_err", 32'(err_timeout), 32'd0);
        checkOutput("last_cycle_ready", 32'(req_ready), 32'd1);
        checkModel("last_cycle");

        // Done high in the first ISSUE cycle is stale and must be ignored.
        useModel  = 1'b0;
        forceDone = 1'b1;
        req_valid = 1'b1;
        req_data  = 3'd2;
        tick();
        req_valid = 1'b0;
        tick();
        checkOutput("stale_done_busy", 32'(busy), 32'd1);
        forceDone = 1'b0;
        useModel  = 1'b1;
        tick();
        expCount++;
        expReg = 3'd2;
        checkOutput("stale_done_ready", 32'(req_ready), 32'd1);
        checkModel("stale_done");

        // Done pulses while idle change nothing.
        useModel  = 1'b0;
        forceDone = 1'b1;
        repeat (3) tick();
        forceDone = 1'b0;
        checkOutput("idle_done_busy", 32'(busy), 32'd0);
        checkModel("idle_done");

        // Fresh start, five writes: the 2-bit counter runs 1,2,3,0,1.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        expCount = 0;
        expReg   = 3'd0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(3'($urandom_range(0, 7)), 1'b0, en, lat);
            checkModel("wrap");
        end

        // Random writes with occasional timeouts and random idle gaps.
        for (int i = 0; i < 24; i++) begin
            useModel = 1'b1;
            repeat ($urandom_range(0, 3)) tick();
            d   = 3'($urandom_range(0, 7));
            tie = ($urandom_range(0, 4) == 0);
            applyStimulus(d, tie, en, lat);
            if (tie) begin
                checkOutput("rand_timeout_en", 32'(en), 32'd8);
                checkOutput("rand_timeout_err", 32'(err_timeout), 32'd1);
                clear_err = 1'b1;
                tick();
                clear_err = 1'b0;
                checkOutput("rand_clear", 32'(err_timeout), 32'd0);
            end else begin
                checkOutput("rand_en", 32'(en), 32'd2);
            end
            checkModel("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
